// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states,
// instruction classes, opcode/funct, ALU, branch and writeback selects.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // Instruction class picks the path through the FSM after EXEC.
    typedef enum logic [1:0] {
        CLS_JMP,
        CLS_ALU,
        CLS_LD,
        CLS_ST
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_ADDU = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_SUBU = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;
    localparam logic [3:0] ALU_SLL  = 4'hA;
    localparam logic [3:0] ALU_SRL  = 4'hB;
    localparam logic [3:0] ALU_SRA  = 4'hC;

    localparam logic [3:0] BR_NONE = 4'b0000;
    localparam logic [3:0] BR_BEQ  = 4'b0001;
    localparam logic [3:0] BR_BNE  = 4'b0010;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_LUI = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;
    localparam logic [1:0] MTR_MEM = 2'b11;

    localparam logic [1:0] SET_SLT  = 2'b01;
    localparam logic [1:0] SET_SLTU = 2'b11;
    localparam logic [1:0] LB_U     = 2'b01;
    localparam logic [1:0] LB_S     = 2'b11;

    typedef struct packed {
        logic [3:0] Branch;
        logic       Jump;
        logic       Jreg;
        logic       ra;
        logic       RegDst;
        logic       ALUsrc_A;
        logic       ALUsrc_B;
        logic       ExtOp;
        logic       Var;
        logic       sbyte;
        logic [3:0] ALUctr;
        logic [1:0] MemtoReg;
        logic [1:0] Set;
        logic [1:0] lbyte;
        cls_t       cls;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational decoder: instr -> datapath select bundle and illegal flag.
// Ports: instr (32b word), dec (select bundle), illegal (unknown op/funct).
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec,
    output logic        illegal
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_fields = ^instr[25:6];

    always_comb begin
        dec        = '0;
        dec.ALUctr = ALU_ADD;
        dec.cls    = CLS_ALU;
        illegal    = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                dec.RegDst = 1'b1;
                unique case (fn)
                    FN_ADD:  dec.ALUctr = ALU_ADD;
                    FN_ADDU: dec.ALUctr = ALU_ADDU;
                    FN_SUB:  dec.ALUctr = ALU_SUB;
                    FN_SUBU: dec.ALUctr = ALU_SUBU;
                    FN_AND:  dec.ALUctr = ALU_AND;
                    FN_OR:   dec.ALUctr = ALU_OR;
                    FN_XOR:  dec.ALUctr = ALU_XOR;
                    FN_NOR:  dec.ALUctr = ALU_NOR;
                    FN_SLT: begin
                        dec.ALUctr = ALU_SLT;
                        dec.Set    = SET_SLT;
                    end
                    FN_SLTU: begin
                        dec.ALUctr = ALU_SLTU;
                        dec.Set    = SET_SLTU;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec.ALUsrc_A = 1'b1;
                        dec.ALUctr   = (fn == FN_SLL) ? ALU_SLL :
                                       (fn == FN_SRL) ? ALU_SRL :
                                                        ALU_SRA;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        dec.ALUsrc_A = 1'b1;
                        dec.Var      = 1'b1;
                        dec.ALUctr   = (fn == FN_SLLV) ? ALU_SLL :
                                       (fn == FN_SRLV) ? ALU_SRL :
                                                         ALU_SRA;
                    end
                    FN_JR: begin
                        dec.RegDst = 1'b0;
                        dec.Jreg   = 1'b1;
                        dec.cls    = CLS_JMP;
                    end
                    FN_JALR: begin
                        dec.Jreg     = 1'b1;
                        dec.MemtoReg = MTR_PC4;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec.ALUsrc_B = 1'b1;
                dec.ExtOp    = 1'b1;
                unique case (op)
                    OP_ADDI:  dec.ALUctr = ALU_ADD;
                    OP_ADDIU: dec.ALUctr = ALU_ADDU;
                    OP_SLTI: begin
                        dec.ALUctr = ALU_SLT;
                        dec.Set    = SET_SLT;
                    end
                    default: begin
                        dec.ALUctr = ALU_SLTU;
                        dec.Set    = SET_SLTU;
                    end
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.ALUsrc_B = 1'b1;
                dec.ALUctr   = (op == OP_ANDI) ? ALU_AND :
                               (op == OP_ORI)  ? ALU_OR  :
                                                 ALU_XOR;
            end
            OP_LUI: begin
                dec.ALUsrc_B = 1'b1;
                dec.MemtoReg = MTR_LUI;
            end
            OP_LW, OP_LB, OP_LBU: begin
                dec.ALUsrc_B = 1'b1;
                dec.ExtOp    = 1'b1;
                dec.ALUctr   = ALU_ADDU;
                dec.MemtoReg = MTR_MEM;
                dec.cls      = CLS_LD;
                dec.lbyte    = (op == OP_LB)  ? LB_S :
                               (op == OP_LBU) ? LB_U : 2'b00;
            end
            OP_SW, OP_SB: begin
                dec.ALUsrc_B = 1'b1;
                dec.ExtOp    = 1'b1;
                dec.ALUctr   = ALU_ADDU;
                dec.sbyte    = (op == OP_SB);
                dec.cls      = CLS_ST;
            end
            OP_BEQ, OP_BNE: begin
                dec.ExtOp  = 1'b1;
                dec.ALUctr = ALU_SUB;
                dec.Branch = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
                dec.cls    = CLS_JMP;
            end
            OP_J: begin
                dec.Jump = 1'b1;
                dec.cls  = CLS_JMP;
            end
            OP_JAL: begin
                dec.Jump     = 1'b1;
                dec.ra       = 1'b1;
                dec.MemtoReg = MTR_PC4;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal words leave every select at zero.
        if (illegal) begin
            dec = '0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM/WB control sequencer with illegal-op HALT.
// Ports: clk, rst (sync, active-low), run, instr -> datapath selects,
// PCWr/RegWr/MemWr one-cycle strobes, halted. Optional MC_PERF_CNT_EN
// adds cycle_cnt and instret counters.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] instr,
    output logic [3:0]  Branch,
    output logic        Jump,
    output logic        Jreg,
    output logic        ra,
    output logic        RegDst,
    output logic        ALUsrc_A,
    output logic        ALUsrc_B,
    output logic        ExtOp,
    output logic        Var,
    output logic        sbyte,
    output logic [3:0]  ALUctr,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  Set,
    output logic [1:0]  lbyte,
    output logic        PCWr,
    output logic        RegWr,
    output logic        MemWr,
    output logic        halted
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
`endif
);

    state_t state_q, state_d;
    dec_t   dec_q, dec_w;
    logic   ill_q, ill_w;
    logic   load_dec;
    logic   pc_wr, reg_wr, mem_wr;

    mc_decode u_dec (
        .instr  (instr),
        .dec    (dec_w),
        .illegal(ill_w)
    );

    always_comb begin
        state_d  = state_q;
        load_dec = 1'b0;
        pc_wr    = 1'b0;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (run) begin
                    load_dec = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ill_q) begin
                    state_d = S_HALT;
                end else begin
                    unique case (dec_q.cls)
                        CLS_JMP: begin
                            pc_wr   = 1'b1;
                            state_d = S_FETCH;
                        end
                        CLS_LD, CLS_ST: state_d = S_MEM;
                        default:        state_d = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (dec_q.cls == CLS_ST) begin
                    mem_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            dec_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_dec) begin
                dec_q <= dec_w;
                ill_q <= ill_w;
            end
        end
    end

    // Reset kills strobes immediately, even before the reset edge.
    assign PCWr   = pc_wr & rst;
    assign RegWr  = reg_wr & rst;
    assign MemWr  = mem_wr & rst;
    assign halted = (state_q == S_HALT);

    assign Branch   = dec_q.Branch;
    assign Jump     = dec_q.Jump;
    assign Jreg     = dec_q.Jreg;
    assign ra       = dec_q.ra;
    assign RegDst   = dec_q.RegDst;
    assign ALUsrc_A = dec_q.ALUsrc_A;
    assign ALUsrc_B = dec_q.ALUsrc_B;
    assign ExtOp    = dec_q.ExtOp;
    assign Var      = dec_q.Var;
    assign sbyte    = dec_q.sbyte;
    assign ALUctr   = dec_q.ALUctr;
    assign MemtoReg = dec_q.MemtoReg;
    assign Set      = dec_q.Set;
    assign lbyte    = dec_q.lbyte;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_q, ret_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (PCWr) begin
                ret_q <= ret_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cyc_q;
    assign instret   = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a per-cycle expectation queue.
// Sel vector: {Branch,Jump,Jreg,ra,RegDst,ALUsrc_A,ALUsrc_B,ExtOp,Var,sbyte,ALUctr,MemtoReg,Set,lbyte}
module tb_multicycle_ctrl;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] instr;
    logic [3:0]  Branch;
    logic        Jump, Jreg, ra, RegDst, ALUsrc_A, ALUsrc_B;
    logic        ExtOp, Var, sbyte;
    logic [3:0]  ALUctr;
    logic [1:0]  MemtoReg, Set, lbyte;
    logic        PCWr, RegWr, MemWr, halted;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret;
`endif

    multicycle_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .instr    (instr),
        .Branch   (Branch),
        .Jump     (Jump),
        .Jreg     (Jreg),
        .ra       (ra),
        .RegDst   (RegDst),
        .ALUsrc_A (ALUsrc_A),
        .ALUsrc_B (ALUsrc_B),
        .ExtOp    (ExtOp),
        .Var      (Var),
        .sbyte    (sbyte),
        .ALUctr   (ALUctr),
        .MemtoReg (MemtoReg),
        .Set      (Set),
        .lbyte    (lbyte),
        .PCWr     (PCWr),
        .RegWr    (RegWr),
        .MemWr    (MemWr),
        .halted   (halted)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt(cycle_cnt),
        .instret  (instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [2:0]  strb;
        logic        hlt;
        logic        chk;
        logic [22:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // f = {Jump,Jreg,ra,RegDst,ALUsrc_A,ALUsrc_B,ExtOp,Var,sbyte}
    function automatic logic [22:0] mk_sel(
        input logic [3:0] br,
        input logic [8:0] f,
        input logic [3:0] alu,
        input logic [1:0] mtr,
        input logic [1:0] st,
        input logic [1:0] lb
    );
        return {br, f, alu, mtr, st, lb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] strb,
                        input logic hlt, input logic c,
                        input logic [22:0] sel);
        exp_t e;
        e.tag  = tag;
        e.strb = strb;
        e.hlt  = hlt;
        e.chk  = c;
        e.sel  = sel;
        exp_q.push_back(e);
    endtask

    // Compare n cycles at negedge+1, one queued expectation each.
    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, "_strb"}, {29'd0, PCWr, RegWr, MemWr},
                    {29'd0, e.strb});
                chk({e.tag, "_halt"}, {31'd0, halted}, {31'd0, e.hlt});
                if (e.chk) begin
                    chk({e.tag, "_sel"},
                        {9'd0, Branch, Jump, Jreg, ra, RegDst,
                         ALUsrc_A, ALUsrc_B, ExtOp, Var, sbyte,
                         ALUctr, MemtoReg, Set, lbyte},
                        {9'd0, e.sel});
                end
            end
            @(negedge clk);
        end
    endtask

    // One instruction from FETCH: strobes only in its final cycle.
    task automatic do_instr(input string tag, input logic [31:0] w,
                            input logic [22:0] sel, input int n,
                            input logic [2:0] last);
        instr = w;
        push(tag, 3'b000, 1'b0, 1'b0, sel);
        for (int i = 1; i < n; i++) begin
            push(tag, (i == n - 1) ? last : 3'b000, 1'b0, 1'b1, sel);
        end
        step(n);
    endtask

    // Illegal word: FETCH, EXEC, then n cycles parked in HALT; then reset.
    task automatic do_halt(input string tag, input logic [31:0] w,
                           input int n);
        instr = w;
        push(tag, 3'b000, 1'b0, 1'b0, '0);
        push(tag, 3'b000, 1'b0, 1'b0, '0);
        for (int i = 0; i < n; i++) begin
            push(tag, 3'b000, 1'b1, 1'b0, '0);
        end
        step(n + 2);
        rst = 1'b0;
        push({tag, "_rst"}, 3'b000, 1'b1, 1'b0, '0);
        step(1);
        rst = 1'b1;
        run = 1'b0;
        push({tag, "_post"}, 3'b000, 1'b0, 1'b1, '0);
        step(1);
        run = 1'b1;
    endtask

    localparam logic [2:0] WB = 3'b110;
    localparam logic [2:0] ST = 3'b101;
    localparam logic [2:0] BR = 3'b100;

    logic [22:0] s_add, s_sw;

    initial begin
        rst   = 1'b0;
        run   = 1'b0;
        instr = '0;
        s_add = mk_sel(BR_NONE, 9'b000100000, ALU_ADD, 2'b00, 2'b00, 2'b00);
        s_sw  = mk_sel(BR_NONE, 9'b000001100, ALU_ADDU, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        @(negedge clk);
        push("reset", 3'b000, 1'b0, 1'b1, '0);
        step(1);
        rst = 1'b1;
        run = 1'b1;

        do_instr("add0", 32'h00221820, s_add, 3, WB);
        do_instr("add1", 32'h00221820, s_add, 3, WB);
        do_instr("add2", 32'h00221820, s_add, 3, WB);
`ifdef MC_PERF_CNT_EN
        #1;
        chk("cycle_cnt", cycle_cnt, 32'd9);
        chk("instret", instret, 32'd3);
`endif
        do_instr("lw", 32'h8C220004,
            mk_sel(BR_NONE, 9'b000001100, ALU_ADDU, 2'b11, 2'b00, 2'b00),
            4, WB);
        do_instr("sb", 32'hA0220008,
            mk_sel(BR_NONE, 9'b000001101, ALU_ADDU, 2'b00, 2'b00, 2'b00),
            3, ST);
        do_instr("beq", 32'h10220003,
            mk_sel(BR_BEQ, 9'b000000100, ALU_SUB, 2'b00, 2'b00, 2'b00),
            2, BR);
        do_instr("jal", 32'h0C000010,
            mk_sel(BR_NONE, 9'b101000000, ALU_ADD, 2'b10, 2'b00, 2'b00),
            3, WB);
        do_instr("lb", 32'h80220001,
            mk_sel(BR_NONE, 9'b000001100, ALU_ADDU, 2'b11, 2'b00, 2'b11),
            4, WB);
        do_instr("lbu", 32'h90220001,
            mk_sel(BR_NONE, 9'b000001100, ALU_ADDU, 2'b11, 2'b00, 2'b01),
            4, WB);
        do_instr("sll", 32'h00021900,
            mk_sel(BR_NONE, 9'b000110000, ALU_SLL, 2'b00, 2'b00, 2'b00),
            3, WB);
        do_instr("srav", 32'h00221807,
            mk_sel(BR_NONE, 9'b000110010, ALU_SRA, 2'b00, 2'b00, 2'b00),
            3, WB);
        do_instr("slti", 32'h28220005,
            mk_sel(BR_NONE, 9'b000001100, ALU_SLT, 2'b00, 2'b01, 2'b00),
            3, WB);
        do_instr("sltiu", 32'h2C220005,
            mk_sel(BR_NONE, 9'b000001100, ALU_SLTU, 2'b00, 2'b11, 2'b00),
            3, WB);
        do_instr("andi", 32'h30220005,
            mk_sel(BR_NONE, 9'b000001000, ALU_AND, 2'b00, 2'b00, 2'b00),
            3, WB);
        do_instr("bne", 32'h14220003,
            mk_sel(BR_BNE, 9'b000000100, ALU_SUB, 2'b00, 2'b00, 2'b00),
            2, BR);
        do_instr("jr", 32'h03E00008,
            mk_sel(BR_NONE, 9'b010000000, ALU_ADD, 2'b00, 2'b00, 2'b00),
            2, BR);
        do_instr("jalr", 32'h0020F809,
            mk_sel(BR_NONE, 9'b010100000, ALU_ADD, 2'b10, 2'b00, 2'b00),
            3, WB);

        do_halt("halt_op", 32'hFC000000, 20);

        // run low: decode register must not load, no strobes.
        run   = 1'b0;
        instr = 32'h00221820;
        for (int i = 0; i < 5; i++) begin
            push("run_lo", 3'b000, 1'b0, 1'b1, '0);
        end
        step(5);
        run = 1'b1;
        do_instr("add_run", 32'h00221820, s_add, 3, WB);

        do_halt("halt_fn", 32'h00000001, 3);

        // Reset during MEM of sw aborts the store.
        instr = 32'hAC220000;
        push("sw_ab", 3'b000, 1'b0, 1'b0, s_sw);
        push("sw_ab", 3'b000, 1'b0, 1'b1, s_sw);
        step(2);
        rst = 1'b0;
        push("sw_rst", 3'b000, 1'b0, 1'b1, s_sw);
        step(1);
        rst = 1'b1;
        run = 1'b0;
        push("sw_post", 3'b000, 1'b0, 1'b1, '0);
        step(1);
        run = 1'b1;
        do_instr("add_end", 32'h00221820, s_add, 3, WB);

        if (exp_q.size() != 0) begin
            chk("sb_left", exp_q.size(), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
